// File: rtl/regfile_hilo_pkg.sv
// ---------------------------------------------------------------------------
// regfile_hilo_pkg
//
// Shared constants and types for the register file and its HI/LO pair.
// These are the core-wide definitions (reset level, enable levels, the zero
// word, the "no register" address, bus widths and register count) so that no
// module in this slice carries its own copy of these literals.
//
// Optional feature macro used by the modules that import this package:
//   REGFILE_BYPASS_EN - same-cycle write-through on GPR reads and HI/LO.
// ---------------------------------------------------------------------------
package regfile_hilo_pkg;

    // Control levels.
    localparam logic RST_ENABLE    = 1'b0;   // rst is active-low
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    // Bus geometry.
    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;
    localparam int REG_NUM_DEF    = 32;

    typedef logic [REG_BUS_W-1:0]      reg_bus_t;
    typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_t;

    localparam reg_bus_t  ZERO_WORD    = '0;
    localparam reg_addr_t NOP_REG_ADDR = '0;

    // True when a read port addresses the register being written this cycle.
    // Address 0 never qualifies because it is never written.
    function automatic logic read_hits_write(
        input logic      re,
        input reg_addr_t raddr,
        input logic      we,
        input reg_addr_t waddr
    );
        return (re == READ_ENABLE) && (we == WRITE_ENABLE) &&
               (raddr == waddr) && (waddr != NOP_REG_ADDR);
    endfunction

endpackage : regfile_hilo_pkg

// File: rtl/regfile_hilo_hilo.sv
// ---------------------------------------------------------------------------
// hilo_reg
//
// HI/LO special-register pair used by the multiply/divide results. Both
// halves load together when we is high and hold otherwise.
//
// Ports
//   clk   in   single clock, rising edge
//   rst   in   synchronous reset, active-low; also forces outputs to zero
//   we    in   HI/LO write enable (wb_whilo)
//   hi_i  in   HI write data
//   lo_i  in   LO write data
//   hi_o  out  HI value
//   lo_o  out  LO value
//
// Optional feature: REGFILE_BYPASS_EN - when defined, hi_o/lo_o return the
// incoming hi_i/lo_i during a write cycle instead of the stored values.
// ---------------------------------------------------------------------------
module hilo_reg
    import regfile_hilo_pkg::*;
#(
    parameter int W = REG_BUS_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam logic [W-1:0] ZERO = W'(ZERO_WORD);

    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_q <= ZERO;
            lo_q <= ZERO;
        end else if (we == WRITE_ENABLE) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    // NOTE: every output is given a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst == RST_ENABLE) begin
            hi_o = ZERO;
            lo_o = ZERO;
        end
`ifdef REGFILE_BYPASS_EN
        else if (we == WRITE_ENABLE) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
`endif
    end

endmodule : hilo_reg

// File: rtl/regfile_hilo.sv
// ---------------------------------------------------------------------------
// regfile_hilo
//
// General-purpose register file (one write port, two independent
// combinational read ports) plus the HI/LO pair. Register 0 is hard-wired to
// zero. A GPR write and a HI/LO write may happen in the same cycle.
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous reset, active-low; clears all state and
//                       forces every read output to zero while low
//   we             in   GPR write enable (wb_wreg)
//   waddr          in   GPR write address (wb_wd)
//   wdata          in   GPR write data (wb_wdata)
//   re1, re2       in   read enables; a disabled port returns zero
//   raddr1, raddr2 in   read addresses
//   rdata1, rdata2 out  read data, combinational
//   whilo          in   HI/LO write enable (wb_whilo)
//   hi_i, lo_i     in   HI/LO write data
//   hi_o, lo_o     out  HI/LO values
//
// Optional feature: REGFILE_BYPASS_EN - when defined, a read of the register
// being written in the same cycle returns wdata, and HI/LO outputs return
// hi_i/lo_i during a HI/LO write. Without it, reads return stored data only
// and the pipeline is expected to stall one cycle on such a hazard.
// ---------------------------------------------------------------------------
module regfile_hilo
    import regfile_hilo_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int REG_W   = REG_BUS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  reg_addr_t        waddr,
    input  logic [REG_W-1:0] wdata,
    input  logic             re1,
    input  reg_addr_t        raddr1,
    input  logic             re2,
    input  reg_addr_t        raddr2,
    output logic [REG_W-1:0] rdata1,
    output logic [REG_W-1:0] rdata2,
    input  logic             whilo,
    input  logic [REG_W-1:0] hi_i,
    input  logic [REG_W-1:0] lo_i,
    output logic [REG_W-1:0] hi_o,
    output logic [REG_W-1:0] lo_o
);

    localparam logic [REG_W-1:0] ZERO = REG_W'(ZERO_WORD);

    // -----------------------------------------------------------------------
    // GPR storage
    // -----------------------------------------------------------------------
    logic [REG_W-1:0] gpr [REG_NUM];

    // NOTE: the whole array is cleared on reset because software relies on
    // every GPR reading zero after reset; this keeps the storage in flops
    // rather than a RAM macro, which cannot be bulk-cleared.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr[i] <= ZERO;
            end
        end else if ((we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR)) begin
            gpr[waddr] <= wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports: identical muxes, one per port
    // -----------------------------------------------------------------------
    logic      port_re    [2];
    reg_addr_t port_raddr [2];

    assign port_re[0]    = re1;
    assign port_re[1]    = re2;
    assign port_raddr[0] = raddr1;
    assign port_raddr[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [REG_W-1:0] rd_val;
        logic             hit;

        // Only consulted in the bypass build; kept in both so the port
        // structure does not change with the macro.
        assign hit = read_hits_write(port_re[p], port_raddr[p], we, waddr);

        // Priority: reset, then r0, then disabled port, then bypass, then
        // storage. r0 sits above bypass so it reads zero unconditionally.
        always_comb begin
            rd_val = ZERO;
            if (rst == RST_ENABLE) begin
                rd_val = ZERO;
            end else if (port_raddr[p] == NOP_REG_ADDR) begin
                rd_val = ZERO;
            end else if (port_re[p] == READ_DISABLE) begin
                rd_val = ZERO;
            end
`ifdef REGFILE_BYPASS_EN
            else if (hit) begin
                rd_val = wdata;
            end
`endif
            else begin
                rd_val = gpr[port_raddr[p]];
            end
        end
    end

    assign rdata1 = g_port[0].rd_val;
    assign rdata2 = g_port[1].rd_val;

    // -----------------------------------------------------------------------
    // HI/LO pair
    // -----------------------------------------------------------------------
    hilo_reg #(
        .W (REG_W)
    ) u_hilo_reg (
        .clk  (clk),
        .rst  (rst),
        .we   (whilo),
        .hi_i (hi_i),
        .lo_i (lo_i),
        .hi_o (hi_o),
        .lo_o (lo_o)
    );

endmodule : regfile_hilo

// File: tb/tb_regfile_hilo.sv
// ---------------------------------------------------------------------------
// tb_regfile_hilo
//
// Stimulus issues one transaction per clock (inputs driven #1 after the
// rising edge). For each one the expected outputs are computed from a
// behavioural model of the register file (plain arrays) and pushed onto a
// scoreboard queue; a monitor pops and compares on every falling edge while
// transactions are flowing. Directed scenarios come first, then random.
// ---------------------------------------------------------------------------
module tb_regfile_hilo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [4:0]   waddr;
    logic [W-1:0] wdata;
    logic         re1, re2;
    logic [4:0]   raddr1, raddr2;
    logic [W-1:0] rdata1, rdata2;
    logic         whilo;
    logic [W-1:0] hi_i, lo_i;
    logic [W-1:0] hi_o, lo_o;

    always #5 clk = ~clk;

    regfile_hilo dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .whilo  (whilo),
        .hi_i   (hi_i),
        .lo_i   (lo_i),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    // ---------------------------------------------------------------------
    // Stimulus and scoreboard types
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic         rst;
        logic         we;
        logic [4:0]   waddr;
        logic [W-1:0] wdata;
        logic         re1;
        logic [4:0]   raddr1;
        logic         re2;
        logic [4:0]   raddr2;
        logic         whilo;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } stim_t;

    typedef struct {
        string        tag;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb [$];
    logic sample_req = 1'b0;

    int tests  = 0;
    int failed = 0;

    // ---------------------------------------------------------------------
    // Reference model: what the architectural state is, in plain arrays
    // ---------------------------------------------------------------------
    logic [W-1:0] m_gpr [32];
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    function automatic logic [W-1:0] model_read(input stim_t s, input logic re,
                                                input logic [4:0] ra);
        if (!s.rst || !re || ra == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (s.we && s.waddr == ra) return s.wdata;
`endif
        return m_gpr[ra];
    endfunction

    function automatic logic [W-1:0] model_hilo(input stim_t s, input logic is_hi);
        if (!s.rst) return '0;
`ifdef REGFILE_BYPASS_EN
        if (s.whilo) return is_hi ? s.hi : s.lo;
`endif
        return is_hi ? m_hi : m_lo;
    endfunction

    // State change at the coming rising edge.
    task automatic model_commit(input stim_t s);
        if (!s.rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = '0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            if (s.we && s.waddr != 5'd0) m_gpr[s.waddr] = s.wdata;
            if (s.whilo) begin
                m_hi = s.hi;
                m_lo = s.lo;
            end
        end
    endtask

    // ---------------------------------------------------------------------
    // Comparison helper
    // ---------------------------------------------------------------------
    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Stimulus driver
    // ---------------------------------------------------------------------
    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic step(input stim_t s, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst    = s.rst;
        we     = s.we;
        waddr  = s.waddr;
        wdata  = s.wdata;
        re1    = s.re1;
        raddr1 = s.raddr1;
        re2    = s.re2;
        raddr2 = s.raddr2;
        whilo  = s.whilo;
        hi_i   = s.hi;
        lo_i   = s.lo;
        e.tag = tag;
        e.r1  = model_read(s, s.re1, s.raddr1);
        e.r2  = model_read(s, s.re2, s.raddr2);
        e.hi  = model_hilo(s, 1'b1);
        e.lo  = model_hilo(s, 1'b0);
        sb.push_back(e);
        sample_req = 1'b1;
        model_commit(s);
    endtask

    // ---------------------------------------------------------------------
    // Monitor: compares whatever the DUT presents against the queue head
    // ---------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sample_req) begin
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
                end else begin
                    e = sb.pop_front();
                    check({e.tag, ".rdata1"}, rdata1, e.r1);
                    check({e.tag, ".rdata2"}, rdata2, e.r2);
                    check({e.tag, ".hi_o"},   hi_o,   e.hi);
                    check({e.tag, ".lo_o"},   lo_o,   e.lo);
                end
            end
        end
    end

    // Watchdog: the run is a fixed-length sequence; this only guards hangs.
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no completion, expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        stim_t s;

        for (int i = 0; i < 32; i++) m_gpr[i] = '0;
        m_hi = '0;
        m_lo = '0;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        whilo = 1'b0; hi_i = '0; lo_i = '0;

        // Reset held two cycles with a write presented; r5 must stay zero.
        s = idle();
        s.rst = 1'b0; s.we = 1'b1; s.waddr = 5'd5; s.wdata = 32'hFFFF_FFFF;
        s.re1 = 1'b1; s.raddr1 = 5'd5;
        step(s, "reset_hold0");
        step(s, "reset_hold1");
        s = idle(); s.re1 = 1'b1; s.raddr1 = 5'd5;
        step(s, "reset_release");

        // Register 0 ignores writes and always reads zero.
        s = idle(); s.we = 1'b1; s.waddr = 5'd0; s.wdata = 32'h1234_5678;
        s.re1 = 1'b1; s.re2 = 1'b1;
        step(s, "r0_write");
        s = idle(); s.re1 = 1'b1; s.re2 = 1'b1;
        step(s, "r0_read");

        // Write r7 then read on port 2; disabled port reads zero.
        s = idle(); s.we = 1'b1; s.waddr = 5'd7; s.wdata = 32'hDEAD_BEEF;
        step(s, "r7_write");
        s = idle(); s.re2 = 1'b1; s.raddr2 = 5'd7;
        step(s, "r7_read");
        s = idle(); s.re2 = 1'b0; s.raddr2 = 5'd7;
        step(s, "r7_re2_off");
        s = idle(); s.re1 = 1'b1; s.raddr1 = 5'd7; s.re2 = 1'b1; s.raddr2 = 5'd7;
        step(s, "r7_both_ports");

        // Same-cycle hazard on r3.
        s = idle(); s.we = 1'b1; s.waddr = 5'd3; s.wdata = 32'h1;
        step(s, "r3_init");
        s = idle(); s.we = 1'b1; s.waddr = 5'd3; s.wdata = 32'h2;
        s.re1 = 1'b1; s.raddr1 = 5'd3;
        step(s, "r3_hazard");
        s = idle(); s.re1 = 1'b1; s.raddr1 = 5'd3;
        step(s, "r3_after");

        // HI/LO load then hold with changing inputs.
        s = idle(); s.whilo = 1'b1; s.hi = 32'hA; s.lo = 32'hB;
        step(s, "hilo_write");
        s = idle(); s.whilo = 1'b0; s.hi = 32'hC; s.lo = 32'hD;
        step(s, "hilo_hold");
        s = idle();
        step(s, "hilo_hold2");

        // GPR and HI/LO written together, then reset drops a concurrent write.
        s = idle(); s.we = 1'b1; s.waddr = 5'd9; s.wdata = 32'h1111_1111;
        s.whilo = 1'b1; s.hi = 32'h2222_2222; s.lo = 32'h3333_3333;
        s.re1 = 1'b1; s.raddr1 = 5'd9;
        step(s, "gpr_hilo_same");
        s = idle(); s.re1 = 1'b1; s.raddr1 = 5'd9;
        step(s, "gpr_hilo_read");
        s = idle(); s.rst = 1'b0; s.we = 1'b1; s.waddr = 5'd9; s.wdata = 32'h5555_5555;
        s.whilo = 1'b1; s.hi = 32'h7777_7777; s.lo = 32'h8888_8888;
        s.re1 = 1'b1; s.raddr1 = 5'd9;
        step(s, "reset_mid_op");
        s = idle(); s.re1 = 1'b1; s.raddr1 = 5'd9; s.re2 = 1'b1; s.raddr2 = 5'd7;
        step(s, "reset_mid_after");

        // Random traffic; addresses drawn from a small pool so reads hit
        // recently written registers and same-cycle hazards are frequent.
        for (int n = 0; n < 800; n++) begin
            s = idle();
            s.rst    = ($urandom_range(0, 39) != 0);
            s.we     = $urandom_range(0, 1);
            s.waddr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(0, 5));
            s.wdata  = $urandom;
            s.re1    = ($urandom_range(0, 4) != 0);
            s.raddr1 = ($urandom_range(0, 2) == 0) ? s.waddr : 5'($urandom_range(0, 5));
            s.re2    = ($urandom_range(0, 4) != 0);
            s.raddr2 = ($urandom_range(0, 2) == 0) ? s.waddr : 5'($urandom_range(0, 31));
            s.whilo  = ($urandom_range(0, 2) == 0);
            s.hi     = $urandom;
            s.lo     = $urandom;
            step(s, "random");
        end

        // Drain: stop sampling, then confirm every expectation was consumed.
        @(posedge clk);
        #1;
        sample_req = 1'b0;
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_regfile_hilo

// File: doc/regfile_hilo.md
REGFILE_HILO -- requirements
Module: regfile_hilo

Interface
REQ-001 The module SHALL have parameter REG_NUM, default 32, meaning the number of general registers, fixed at 32 for this core.
REQ-002 The module SHALL have parameter REG_W, default 32, meaning the data width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst == 0 resets).
REQ-005 we  input  1  GPR write enable, driven by wb_wreg.
REQ-006 waddr  input  5  GPR write address, driven by wb_wd.
REQ-007 wdata  input  32  GPR write data, driven by wb_wdata.
REQ-008 re1 / re2  input  1 each  read enables for ports 1 and 2.
REQ-009 raddr1 / raddr2  input  5 each  read addresses.
REQ-010 rdata1 / rdata2  output  32 each  read data, combinational.
REQ-011 whilo  input  1  HI/LO write enable, driven by wb_whilo.
REQ-012 hi_i / lo_i  input  32 each  HI/LO write data.
REQ-013 hi_o / lo_o  output  32 each  HI/LO values.

Function
REQ-014 GPR write SHALL occur on the rising clk edge when rst is high, we is 1 and waddr is not 0; the write is visible in storage from the next cycle.
REQ-015 Register 0 SHALL never be written; any read of address 0 SHALL return 0 regardless of bypass.
REQ-016 Each read port SHALL return 0 when its re is 0.
REQ-017 Each read port SHALL return storage[raddr] when its re is 1, except where REQ-024 applies.
REQ-018 Both read ports SHALL be independent; both SHALL be able to read the same address in one cycle.
REQ-019 HI and LO SHALL both load hi_i and lo_i on the rising edge when whilo is 1; they SHALL hold when whilo is 0.
REQ-020 hi_o and lo_o SHALL reflect registered HI/LO, except where REQ-025 applies.
REQ-021 A GPR write and a HI/LO write in the same cycle SHALL both take effect.

Reset
REQ-022 On a rising edge with rst == 0, the module SHALL clear HI and LO to 0 and clear all GPRs to 0, and SHALL ignore any write in progress, including a write presented in that same cycle.
REQ-023 While rst == 0, the module SHALL force rdata1, rdata2, hi_o and lo_o to 0 combinationally.

Configuration
REQ-024 With REGFILE_BYPASS_EN defined: a read port with re == 1, raddr == waddr != 0 and we == 1 in the same cycle SHALL return wdata (write-through).
REQ-025 With REGFILE_BYPASS_EN defined: when whilo == 1, hi_o and lo_o SHALL return hi_i and lo_i in the same cycle.
REQ-026 Without REGFILE_BYPASS_EN: reads SHALL return only stored values (old data during a same-cycle write); the pipeline then stalls one cycle on such a hazard.

Structure
REQ-027 RstEnable, WriteEnable/Disable, ReadEnable/Disable, ZeroWord, NOPRegAddr, RegBus, RegAddrBus and RegNum SHALL come from the shared defines.v; the module SHALL NOT use local literals for them.
REQ-028 The HI/LO pair SHALL be a sub-module hilo_reg (clk, rst, we, hi_i, lo_i, hi_o, lo_o) instantiated once.
REQ-029 GPR storage and the read muxes SHALL live in the top module.

Verification
REQ-030 Reset: hold rst=0 for 2 cycles with we=1, waddr=5, wdata=32'hFFFF_FFFF, then release -> reading raddr1=5 returns 0, hi_o=lo_o=0.
REQ-031 Zero register: write waddr=0, wdata=32'h1234_5678, then read raddr1=raddr2=0, re=1 -> both return 0.
REQ-032 Write then read: write r7=32'hDEAD_BEEF at cycle N, read r7 on port 2 at N+1 -> 32'hDEAD_BEEF; with re2=0 -> 0.
REQ-033 Same-cycle hazard: r3 holds 32'h1; in one cycle we=1, waddr=3, wdata=32'h2 and read raddr1=3 -> with REGFILE_BYPASS_EN returns 32'h2, without it returns 32'h1; next cycle returns 32'h2 in both builds.
REQ-034 HI/LO: whilo=1, hi_i=32'hA, lo_i=32'hB for one cycle, then whilo=0 with hi_i=32'hC -> hi_o=32'hA and lo_o=32'hB held; with bypass, hi_o=32'hA during the write cycle.
REQ-035 Reset mid-operation: issue a write of r9 and a HI/LO write in the same cycle with rst=0 -> r9, HI and LO all read 0 after release.
